// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte handshake between the LED sequencer and uart_tx
interface uart_tx_if;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;

    modport master (output data_in, output valid, input ready);
    modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART frame serialiser on the system clock; UART_TX_PARITY_EN adds an even parity bit
module uart_tx #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD        = 115200
) (
    input  logic     CLK,
    input  logic     RESET,
    uart_tx_if.slave tx_in,
    output logic     TXD,
    output logic     busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx: CLK_FREQ_HZ / BAUD must be at least 2");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic baud_done;
    logic accept;

    assign baud_done   = (baud_q == BAUD_LAST);
    assign tx_in.ready = (state_q == ST_IDLE) && !RESET;
    assign accept      = tx_in.valid && tx_in.ready;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        if (state_q != ST_IDLE) begin
            baud_d = baud_done ? '0 : baud_q + 1'b1;
        end

        // TXD is loaded one edge ahead of each bit so the pin is a pure flop output
        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (accept) begin
                    shift_d   = tx_in.data_in;
                    bit_idx_d = 3'd0;
                    baud_d    = '0;
                    txd_d     = 1'b0;
                    state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^tx_in.data_in;
`endif
                end
            end
            ST_START: begin
                if (baud_done) begin
                    txd_d   = shift_q[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = parity_q;
                        state_d = ST_PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_done) begin
                    txd_d   = 1'b1;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                txd_d = 1'b1;
                if (baud_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign TXD  = txd_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that drives the SOC `TXD` pin, directly downstream of the LED pattern sequencer. It accepts one byte per valid/ready handshake: the sequencer's 5-bit LED value, zero-extended to 8 bits. It serialises each byte as an 8N1 UART frame (start bit, 8 data bits LSB first, optional parity, stop bit). Bit timing comes from an internal baud counter running on the system clock, so no separate baud clock is needed.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 12000000: frequency of `CLK` in Hz.
- `BAUD`, default 115200: line rate in bits per second.
- Derived `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD`, using truncating integer division. It must be ≥ 2; elaboration fails otherwise.

Ports:
- `CLK` input 1: system clock. One clock domain; all state updates on the rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `data_in` input 8: byte to send. Sampled only on the accepting edge.
- `valid` input 1: producer has a byte on `data_in`.
- `ready` output 1: transmitter can accept a byte this cycle.
- `TXD` output 1: serial line, idle high.
- `busy` output 1: a frame is in progress.

## Operation
- States: IDLE, START, DATA, PARITY (compiled in only with the macro), STOP.
- Handshake:
  - A transfer occurs on any rising edge where `valid && ready`.
  - `ready` is high only in IDLE, and is low while `RESET` is high.
  - `valid` may stay high across frames. The producer must hold `data_in` stable while `valid && !ready`.
- On accept:
  - `data_in` is latched into a shift register.
  - The state goes to START and `TXD` is registered low.
- Baud counter:
  - Counts 0 to `CLKS_PER_BIT-1` in every non-IDLE state.
  - At terminal count it wraps to 0 and the state machine advances.
- DATA state:
  - Shifts out bit 0 first.
  - A 3-bit index counts 0 to 7; the state leaves DATA after index 7 completes.
- Transitions:
  - START → DATA.
  - DATA → PARITY when the macro is defined, otherwise DATA → STOP.
  - PARITY → STOP.
  - STOP (`TXD` = 1) → IDLE.
- `busy` equals (state != IDLE). `TXD` is a registered output with no combinational path from the inputs.
- Input changes on `data_in` or `valid` during a frame have no effect on the frame.
- Reset:
  - While `RESET` is high, the next edge forces state IDLE, `TXD` = 1, baud and bit counters = 0, and the shift register = 0. This applies mid-frame too; the partial frame is abandoned with no stop-bit completion.
  - Reset values: `TXD` = 1, `busy` = 0, `ready` = 0 while `RESET` is asserted, and `ready` = 1 from the first cycle after release.
  - A byte presented during reset is not accepted.

## Timing
- Latency: `TXD` falls on the same edge that accepts the byte, so the start bit is visible the cycle after the handshake.
- Each bit, including start and stop, holds exactly `CLKS_PER_BIT` cycles.
- Frame length is `10*CLKS_PER_BIT` cycles, or `11*CLKS_PER_BIT` with parity.
- After the last stop cycle, the block spends one IDLE cycle with `ready` = 1. The back-to-back accept happens on that edge.
- Minimum start-to-start spacing is therefore `10*CLKS_PER_BIT + 1` cycles (`11*CLKS_PER_BIT + 1` with parity).
- `ready` falls on the accepting edge and rises on the edge that ends the stop bit.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - An even-parity bit is inserted between data bit 7 and the stop bit.
  - The parity bit is the XOR of the 8 latched data bits.
  - Frame is 11 bits.
- Undefined: no PARITY state, 8N1 framing, 10-bit frame.

## Test plan
All scenarios use `CLK_FREQ_HZ`=16 and `BAUD`=4, so `CLKS_PER_BIT`=4.
- **Reset:** hold `RESET` for 3 cycles with `valid`=1 → `TXD`=1, `ready`=0 and `busy`=0 throughout. `ready`=1 on the first cycle after release, and the byte is accepted on that edge.
- **Single frame:** send 0x55 → `TXD` carries 0, 1,0,1,0,1,0,1,0, 1, each level held for exactly 4 cycles. `busy`=1 for 40 cycles, then `ready`=1.
- **Back-to-back:** hold `valid`=1 with 0xA5 and then 0x3C → second start bit falls exactly 41 cycles after the first. Both frames decode correctly by LSB-first sampling at bit centres.
- **Reset mid-frame:** assert `RESET` 15 cycles into a 0x0F frame → `TXD`=1 and `busy`=0 on the next cycle. No further transitions occur, and a new byte is accepted on the first cycle after release.
- **Input stability:** toggle `data_in` every cycle during a 0x81 frame → the transmitted bits still equal 0x81.
- **Parity (`UART_TX_PARITY_EN` defined):**
  - 0x07 → parity bit 1 at bit position 9, 44-cycle frame, start-to-start spacing 45.
  - 0x03 → parity bit 0.
